// File: rtl/feeder_pkg.sv
// Shared types and constants for the serial bit feeder.
package feeder_pkg;

    // Serialiser control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Meaning of the per-word direction bit.
    localparam logic DIR_LSB_FIRST = 1'b1;
    localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/feeder_slot.sv
// Single-entry holding register between the upstream handshake and the
// active shifter. A write always wins over a read, so a word arriving in
// the same cycle the previous one leaves keeps the slot full.
module feeder_slot #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [WIDTH:0] wr_data,
    input  logic           rd_en,
    output logic [WIDTH:0] rd_data,
    output logic           full
);

    logic [WIDTH:0] data_q;

    // Occupancy flag: set on write, cleared on read, write has priority.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    // Payload capture on write.
    // NOTE: the payload has no reset; it is only ever read while full=1,
    // and leaving it unreset keeps it a plain enable register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q <= wr_data;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises parallel words one bit per clock toward the bidirectional
// shift register, with a one-word pending slot so consecutive words can
// stream without a bubble, and an optional idle gap after each word.
module serial_bit_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dataIn,
    output logic             direction,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WIDTH-1:0] word_q;
    logic             dir_q;

    logic             slot_full;
    logic [WIDTH:0]   slot_rd_data;
    logic             accept;
    logic             load;
    logic             last_bit;
    logic             gap_last;
    logic             active_free;
    logic [CNT_W-1:0] bit_idx;

    // Ready depends only on the slot flop, never on in_valid.
    assign in_ready = !slot_full;
    assign accept   = in_valid && in_ready;

    feeder_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data ({in_data, in_dir}),
        .rd_en   (load),
        .rd_data (slot_rd_data),
        .full    (slot_full)
    );

    // Decide when the active shifter can take the pending word.
    always_comb begin
        last_bit    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        gap_last    = HAS_GAP && (state_q == GAP) && (gap_q == GAP_LAST);
        active_free = (state_q == IDLE) || (last_bit && !HAS_GAP) || gap_last;
        load        = active_free && slot_full;
    end

    // Next-state, counter and output decode.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        bit_valid = 1'b0;
        word_done = 1'b0;
        bit_idx   = '0;
        dataIn    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                bit_valid = 1'b1;
                word_done = last_bit;
                if (!last_bit) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (load) begin
                    // Reload straight from the slot: no idle bit between words.
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            GAP: begin
                if (!gap_last) begin
                    gap_d = gap_q + 1'b1;
                end else if (load) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Pick the bit for this count in the word's own direction.
        bit_idx = (dir_q == DIR_LSB_FIRST) ? cnt_q : (CNT_LAST - cnt_q);
        dataIn  = bit_valid & word_q[bit_idx];
    end

    assign direction = dir_q;
    assign busy      = (state_q != IDLE) || slot_full;

    // State, counters and the active word; the word and its direction
    // change only when a new word is loaded, so direction is stable
    // for the whole word and holds its last value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            if (load) begin
                word_q <= slot_rd_data[WIDTH:1];
                dir_q  <= slot_rd_data[0];
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one instance back-to-back
// (GAP_CYCLES=0) and one with a three-cycle gap (GAP_CYCLES=3).
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_dir;
    logic       drv_valid;
    logic       sel;

    logic v0, vg;
    logic rdy0, dat0, dir0, bv0, wd0, busy0;
    logic rdyg, datg, dirg, bvg, wdg, busyg;
    logic m_rdy, m_dat, m_dir, m_bv, m_wd, m_busy;

    int checks   = 0;
    int failures = 0;

    logic [127:0] bv_rec, dat_rec, dir_rec, wd_rec, rdy_rec, busy_rec;
    logic [7:0]   wq_data [0:3];
    logic         wq_dir  [0:3];
    logic [7:0]   bp_tab  [0:32];

    always #5 clk = ~clk;

    assign v0 = drv_valid & ~sel;
    assign vg = drv_valid & sel;

    assign m_rdy  = sel ? rdyg  : rdy0;
    assign m_dat  = sel ? datg  : dat0;
    assign m_dir  = sel ? dirg  : dir0;
    assign m_bv   = sel ? bvg   : bv0;
    assign m_wd   = sel ? wdg   : wd0;
    assign m_busy = sel ? busyg : busy0;

    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_valid  (v0),
        .in_ready  (rdy0),
        .dataIn    (dat0),
        .direction (dir0),
        .bit_valid (bv0),
        .word_done (wd0),
        .busy      (busy0)
    );

    serial_bit_feeder #(.WIDTH(8), .GAP_CYCLES(3)) dut_g (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_valid  (vg),
        .in_ready  (rdyg),
        .dataIn    (datg),
        .direction (dirg),
        .bit_valid (bvg),
        .word_done (wdg),
        .busy      (busyg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack len recorded samples starting at index from; earliest ends up MSB.
    function automatic logic [31:0] pack(input logic [127:0] r, input int from, input int len);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < len; i++) begin
            p = {p[30:0], r[from + i]};
        end
        return p;
    endfunction

    task automatic clear_rec();
        bv_rec   = '0;
        dat_rec  = '0;
        dir_rec  = '0;
        wd_rec   = '0;
        rdy_rec  = '0;
        busy_rec = '0;
    endtask

    task automatic record(input int k);
        bv_rec[k]   = m_bv;
        dat_rec[k]  = m_dat;
        dir_rec[k]  = m_dir;
        wd_rec[k]   = m_wd;
        rdy_rec[k]  = m_rdy;
        busy_rec[k] = m_busy;
    endtask

    // Offer nw queued words with valid held until taken; sample k is
    // taken 1 time unit after the k-th clock edge of the run.
    task automatic run_stream(input int nw, input int ncyc);
        int head;
        bit acc;
        head = 0;
        clear_rec();
        for (int k = 0; k < ncyc; k++) begin
            drv_valid = (head < nw);
            if (head < nw) begin
                in_data = wq_data[head];
                in_dir  = wq_dir[head];
            end
            acc = drv_valid && m_rdy;
            tick();
            if (acc) head++;
            record(k);
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        drv_valid = 1'b0;
        sel       = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        for (int k = 0; k <= 32; k++) bp_tab[k] = 8'((k * 37) + 11);

        // Reset state
        tick();
        tick();
        check("rst_ready",  32'(rdy0),  32'd1);
        check("rst_data",   32'(dat0),  32'd0);
        check("rst_dir",    32'(dir0),  32'd1);
        check("rst_bv",     32'(bv0),   32'd0);
        check("rst_wd",     32'(wd0),   32'd0);
        check("rst_busy",   32'(busy0), 32'd0);
        check("rst_g_rdy",  32'(rdyg),  32'd1);
        check("rst_g_busy", 32'(busyg), 32'd0);
        reset = 1'b0;
        tick();

        // Single word A5, LSB first
        wq_data[0] = 8'hA5; wq_dir[0] = 1'b1;
        run_stream(1, 10);
        check("a5_seq",   pack(dat_rec, 1, 8),  32'b1010_0101);
        check("a5_bv",    pack(bv_rec, 0, 10),  32'h1FE);
        check("a5_wd",    pack(wd_rec, 1, 8),   32'h01);
        check("a5_dir",   pack(dir_rec, 1, 8),  32'hFF);
        check("a5_rdy",   pack(rdy_rec, 0, 10), 32'h1FF);
        check("a5_idle",  32'(busy_rec[9]),     32'd0);

        // Single word 0F, MSB first
        wq_data[0] = 8'h0F; wq_dir[0] = 1'b0;
        run_stream(1, 10);
        check("0f_seq",   pack(dat_rec, 1, 8),  32'b0000_1111);
        check("0f_dir",   pack(dir_rec, 1, 9),  32'h0);
        check("0f_bv",    pack(bv_rec, 0, 10),  32'h1FE);

        // Back-to-back FF (LSB first) then 00 (MSB first)
        wq_data[0] = 8'hFF; wq_dir[0] = 1'b1;
        wq_data[1] = 8'h00; wq_dir[1] = 1'b0;
        run_stream(2, 20);
        check("b2b_bv",   pack(bv_rec, 0, 18),  32'h1FFFE);
        check("b2b_data", pack(dat_rec, 1, 16), 32'hFF00);
        check("b2b_dir",  pack(dir_rec, 1, 16), 32'hFF00);
        check("b2b_wd",   pack(wd_rec, 1, 16),  32'h0101);
        check("b2b_rdy",  pack(rdy_rec, 0, 18), 32'h101FF);

        // Three-cycle gap between two queued words
        sel = 1'b1;
        wq_data[0] = 8'hC3; wq_dir[0] = 1'b1;
        wq_data[1] = 8'h1E; wq_dir[1] = 1'b1;
        run_stream(2, 22);
        check("gap_bv",   pack(bv_rec, 1, 19),  32'h7F8FF);
        check("gap_wd",   pack(wd_rec, 1, 19),  32'h801);
        check("gap_w2",   pack(dat_rec, 12, 8), 32'h78);
        check("gap_tail", pack(bv_rec, 20, 2),  32'h0);
        sel = 1'b0;

        // Reset on the 4th bit of 3C with 81 pending
        wq_data[0] = 8'h3C; wq_dir[0] = 1'b0;
        wq_data[1] = 8'h81; wq_dir[1] = 1'b0;
        run_stream(2, 5);
        check("mid_bits", pack(dat_rec, 1, 4),  32'b0011);
        check("mid_pend", 32'(rdy_rec[4]),      32'd0);
        reset = 1'b1;
        tick();
        check("mid_rst_bv",   32'(bv0),   32'd0);
        check("mid_rst_rdy",  32'(rdy0),  32'd1);
        check("mid_rst_dir",  32'(dir0),  32'd1);
        check("mid_rst_wd",   32'(wd0),   32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        reset = 1'b0;
        run_stream(0, 12);
        check("mid_discard", pack(bv_rec, 0, 12) | pack(wd_rec, 0, 12), 32'h0);
        wq_data[0] = 8'h96; wq_dir[0] = 1'b1;
        run_stream(1, 10);
        check("post_seq", pack(dat_rec, 1, 8),  32'b0110_1001);
        check("post_bv",  pack(bv_rec, 0, 10),  32'h1FE);

        // Backpressure: valid held, data changing every cycle, MSB first
        clear_rec();
        for (int k = 0; k < 33; k++) begin
            drv_valid = 1'b1;
            in_data   = bp_tab[k];
            in_dir    = 1'b0;
            tick();
            record(k);
        end
        drv_valid = 1'b0;
        check("bp_bv",  pack(bv_rec, 0, 1) | 32'(pack(bv_rec, 1, 32) != 32'hFFFF_FFFF), 32'h0);
        check("bp_w0",  pack(dat_rec, 1, 8),  32'(bp_tab[0]));
        check("bp_w1",  pack(dat_rec, 9, 8),  32'(bp_tab[2]));
        check("bp_w2",  pack(dat_rec, 17, 8), 32'(bp_tab[10]));
        check("bp_w3",  pack(dat_rec, 25, 8), 32'(bp_tab[18]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
